// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
//   state_e   : controller states (IDLE, CALC, DONE)
//   digit_t   : recoded Booth digit {neg, zero, two}
//   n_digits  : number of radix-4 digits for a given operand width
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic neg;
      logic zero;
      logic two;
   } digit_t;

   // Operands are widened by two bits before recoding, which adds one digit.
   function automatic int n_digits(input int width);
      return width / 2 + 1;
   endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window {b[2k+1], b[2k], b[2k-1]}
// onto a signed digit in {-2, -1, 0, +1, +2}.
//   win_i : 3-bit window
//   dig_o : {neg, zero, two}; magnitude is 2 when two=1, else 1 (unless zero)
module booth_digit_enc
   import booth_pkg::*;
(
   input  logic [2:0] win_i,
   output digit_t     dig_o
);

   always_comb begin
      dig_o = '{neg: 1'b0, zero: 1'b1, two: 1'b0};
      case (win_i)
         3'b001, 3'b010: dig_o = '{neg: 1'b0, zero: 1'b0, two: 1'b0};
         3'b011:         dig_o = '{neg: 1'b0, zero: 1'b0, two: 1'b1};
         3'b100:         dig_o = '{neg: 1'b1, zero: 1'b0, two: 1'b1};
         3'b101, 3'b110: dig_o = '{neg: 1'b1, zero: 1'b0, two: 1'b0};
         default:        ;
      endcase
   end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock.
// Optional feature macro: BOOTH_EARLY_TERM_EN (skip trailing zero digits with a
// single barrel shift once the remaining multiplier bits are pure sign).
//
// Ports:
//   clk_i        clock
//   rst_n_i      async active-low reset
//   in_valid_i   operand pair valid        in_ready_o  accepting (IDLE only)
//   a_i, b_i     multiplicand / multiplier signed_i    two's complement when 1
//   out_valid_o  product valid             out_ready_i consumer accepts product
//   product_o    full 2*WIDTH product      busy_o      high in CALC or DONE
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for an operand pair; in_ready_o high
// CALC  | retiring one Booth digit per cycle, cnt_q counts down
// DONE  | product valid, held until out_ready_i
module booth_mult_seq
   import booth_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   input  logic               signed_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [2*WIDTH-1:0] product_o,
   output logic               busy_o
);

   localparam int N  = n_digits(WIDTH);
   localparam int CW = $clog2(N);
   localparam int EW = WIDTH + 2;      // extended operand width
   localparam int PW = WIDTH + 3;      // partial product width (room for 2*a)
   localparam int AW = 2 * WIDTH + 4;  // accumulator width

   state_e                state_q, state_d;
   logic [EW-1:0]         a_q, a_d;
   logic [EW-1:0]         b_q, b_d;
   logic                  bprev_q, bprev_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic signed [AW-1:0]  acc_q, acc_d;

   logic [EW-1:0]         a_ext, b_ext;
   digit_t                dig;
   logic [PW-1:0]         mag, pp;
   logic signed [AW-1:0]  acc_shr, acc_step;

   assign a_ext = signed_i ? {{2{a_i[WIDTH-1]}}, a_i} : {2'b00, a_i};
   assign b_ext = signed_i ? {{2{b_i[WIDTH-1]}}, b_i} : {2'b00, b_i};

   // b_q is shifted right by two each digit, so the current window is always
   // at the bottom; bprev_q carries b[2k-1] across the shift.
   booth_digit_enc u_enc (
      .win_i ({b_q[1], b_q[0], bprev_q}),
      .dig_o (dig)
   );

   always_comb begin
      mag = '0;
      if (!dig.zero) begin
         mag = dig.two ? {a_q, 1'b0} : {a_q[EW-1], a_q};
      end
      pp = dig.neg ? (~mag + PW'(1)) : mag;
   end

   // Shift-then-add: digit k lands at weight 2^(2k+1), so the product sits one
   // bit up in the accumulator and no low-order bit is ever shifted out.
   always_comb begin
      acc_shr  = acc_q >>> 2;
      acc_step = acc_shr + {pp, {(WIDTH + 1){1'b0}}};
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      bprev_d = bprev_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               a_d     = a_ext;
               b_d     = b_ext;
               bprev_d = 1'b0;
               cnt_d   = CW'(N - 1);
               acc_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d   = acc_step;
            b_d     = {{2{b_q[EW-1]}}, b_q[EW-1:2]};
            bprev_d = b_q[1];
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = DONE;
            end
`ifdef BOOTH_EARLY_TERM_EN
            // Remaining bits all equal the sign: every later digit is zero, so
            // only their right shifts remain to be applied.
            if (b_q[EW-1:1] == {(EW - 1){b_q[EW-1]}}) begin
               acc_d   = acc_step >>> {cnt_q, 1'b0};
               state_d = DONE;
            end
`endif
         end
         DONE: begin
            if (out_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         bprev_q <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         bprev_q <= bprev_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);
   assign product_o   = acc_q[2*WIDTH:1];

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        sgn;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] product;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;

   booth_mult_seq #(.WIDTH(32)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .a_i         (a_in),
      .b_i         (b_in),
      .signed_i    (sgn),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .product_o   (product),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [63:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Cycle (handshake = cycle 0) in which out_valid should rise.
   function automatic int exp_lat(input logic [31:0] b, input logic s);
      int lat;
      logic [33:0] be;
      be  = s ? {{2{b[31]}}, b} : {2'b00, b};
      lat = 18;
`ifdef BOOTH_EARLY_TERM_EN
      for (int k = 16; k >= 0; k--) begin
         logic all_eq;
         all_eq = 1'b1;
         for (int i = 2 * k + 1; i <= 33; i++) begin
            if (be[i] != be[33]) all_eq = 1'b0;
         end
         if (all_eq) lat = k + 2;
      end
`endif
      return lat;
   endfunction

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
      logic [63:0] ae, be;
      ae = s ? {{32{a[31]}}, a} : {32'h0, a};
      be = s ? {{32{b[31]}}, b} : {32'h0, b};
      return ae * be;
   endfunction

   // Caller is #1 after a rising edge with the DUT in IDLE.
   task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [63:0] p, output int lat);
      in_valid = 1'b1;
      a_in     = a;
      b_in     = b;
      sgn      = s;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      p = product;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   vec_t        vecs[12];
   logic [63:0] p;
   int          lat;
   logic [63:0] held;

   initial begin
      vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
      vecs[1]  = '{32'hFFFFFFF9, 32'h00000006, 1'b1, 64'hFFFFFFFFFFFFFFD6};
      vecs[2]  = '{32'hFFFFFFF9, 32'h00000006, 1'b0, 64'h00000005FFFFFFD6};
      vecs[3]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
      vecs[4]  = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC000000080000000};
      vecs[5]  = '{32'h00000000, 32'h12345678, 1'b1, 64'h0};
      vecs[6]  = '{32'h00000064, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFFFFFFFF9C};
      vecs[7]  = '{32'h00000003, 32'h00000005, 1'b0, 64'h000000000000000F};
      vecs[8]  = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 64'hFFFFFFFFFFFFFFFF};
      vecs[9]  = '{32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000};
      vecs[10] = '{32'hFFFF0000, 32'h00010000, 1'b1, 64'hFFFFFFFF00000000};
      vecs[11] = '{32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a_in = '0; b_in = '0; sgn = 1'b0;
      #12;
      chk("reset in_ready",  {63'h0, in_ready},  64'h1);
      chk("reset out_valid", {63'h0, out_valid}, 64'h0);
      chk("reset busy",      {63'h0, busy},      64'h0);
      chk("reset product",   product,            64'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         run_txn(vecs[i].a, vecs[i].b, vecs[i].s, p, lat);
         chk($sformatf("vec%0d product", i), p, vecs[i].exp);
         chk($sformatf("vec%0d latency", i), 64'(lat), 64'(exp_lat(vecs[i].b, vecs[i].s)));
         consume();
         chk($sformatf("vec%0d idle after consume", i), {63'h0, in_ready}, 64'h1);
      end

      // Backpressure: product and handshake state frozen while out_ready low.
      run_txn(32'hFFFFFFF9, 32'h00000006, 1'b1, p, lat);
      held = p;
      chk("bp product", p, 64'hFFFFFFFFFFFFFFD6);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk($sformatf("bp%0d product", c), product, 64'hFFFFFFFFFFFFFFD6);
         chk($sformatf("bp%0d out_valid", c), {63'h0, out_valid}, 64'h1);
         chk($sformatf("bp%0d in_ready", c), {63'h0, in_ready}, 64'h0);
      end
      consume();
      chk("bp release in_ready",  {63'h0, in_ready},  64'h1);
      chk("bp release out_valid", {63'h0, out_valid}, 64'h0);

      // Reset abort in CALC cycle 5.
      in_valid = 1'b1; a_in = 32'h12345678; b_in = 32'h9ABCDEF0; sgn = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      chk("abort busy before reset", {63'h0, busy}, 64'h1);
      #3 rst_n = 1'b0;
      #1;
      chk("abort in_ready",  {63'h0, in_ready},  64'h1);
      chk("abort out_valid", {63'h0, out_valid}, 64'h0);
      chk("abort busy",      {63'h0, busy},      64'h0);
      chk("abort product",   product,            64'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_txn(32'h00000007, 32'hFFFFFFFD, 1'b1, p, lat);
      chk("post-abort product", p, 64'hFFFFFFFFFFFFFFEB);
      consume();

      // in_valid held high across a transaction: second pair taken only in IDLE.
      in_valid = 1'b1; a_in = 32'h00000009; b_in = 32'h0000000B; sgn = 1'b0;
      @(posedge clk); #1;
      a_in = 32'h00000002; b_in = 32'h00000003;
      lat = 1;
      while (!out_valid && lat < 200) begin
         chk($sformatf("hold in_ready c%0d", lat), {63'h0, in_ready}, 64'h0);
         @(posedge clk); #1;
         lat++;
      end
      chk("hold first product", product, 64'd99);
      chk("hold first latency", 64'(lat), 64'(exp_lat(32'h0000000B, 1'b0)));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("hold idle accepts", {63'h0, in_ready}, 64'h1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("hold second busy", {63'h0, busy}, 64'h1);
      lat = 2;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("hold second product", product, 64'd6);
      consume();

      // Random pairs against a reference multiply.
      for (int r = 0; r < 40; r++) begin
         logic [31:0] ra, rb;
         logic        rs;
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         if (r % 8 == 0) rb = 32'($urandom_range(0, 7));
         run_txn(ra, rb, rs, p, lat);
         chk($sformatf("rand%0d product", r), p, ref_mul(ra, rb, rs));
         chk($sformatf("rand%0d latency", r), 64'(lat), 64'(exp_lat(rb, rs)));
         consume();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
